tmds_decoder: RTL

TMDS_DECODER -- requirements
Module: tmds_decoder

---
 rtl/tmds_decoder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: bit-slip word alignment, two-stage symbol decode and lock FSM.
// Define TMDS_DECODER_ERRCNT_EN to build the coding-rule checker and err_count.
module tmds_decoder #(
    parameter int SEARCH_CYCLES = 1024,
    parameter int LOCK_TOKENS   = 16,
    parameter int LOSS_CYCLES   = 4096
) (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic [9:0]  tmds_raw,
    output logic [7:0]  vd,
    output logic [1:0]  cd,
    output logic        vde,
    output logic        locked,
    output logic [3:0]  offset,
    output logic        sym_err,
    output logic [15:0] err_count
);
    localparam int SW = $clog2(SEARCH_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TOKENS + 1);
    localparam int LW = $clog2(LOSS_CYCLES + 1);
    localparam logic [SW-1:0] SRCH_LAST = SW'(SEARCH_CYCLES - 1);
    localparam logic [TW-1:0] TOK_LAST  = TW'(LOCK_TOKENS - 1);
    localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CYCLES - 1);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    function automatic logic is_token(input logic [9:0] q);
        return (q == 10'b1101010100) || (q == 10'b0010101011) ||
               (q == 10'b0101010100) || (q == 10'b1010101011);
    endfunction

    function automatic logic [1:0] token_cd(input logic [9:0] q);
        case (q)
            10'b0010101011: return 2'b01;
            10'b0101010100: return 2'b10;
            10'b1010101011: return 2'b11;
            default:        return 2'b00;
        endcase
    endfunction

    function automatic logic [7:0] tmds_data(input logic [9:0] q);
        logic [7:0] d;
        logic [7:0] v;
        d    = q[7:0] ^ {8{q[9]}};
        v[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            v[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return v;
    endfunction

    state_t          state_q;
    logic [3:0]      offset_q;
    logic [SW-1:0]   srch_cnt_q;
    logic [TW-1:0]   tok_cnt_q;
    logic [LW-1:0]   loss_cnt_q;
    logic [9:0]      raw_prev_q;
    logic [9:0]      sym_q;
    logic [9:0]      aligned;
    logic [7:0]      vd_q, vd_d;
    logic [1:0]      cd_q, cd_d;
    logic            vde_q, vde_d;
    logic            sym_tok;
    logic [7:0]      sym_vd;

    // Bit 9 of the current word is never inside a 10-bit window at offsets 0..9.
    assign aligned = 10'({tmds_raw[8:0], raw_prev_q} >> offset_q);

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            raw_prev_q <= '0;
            sym_q      <= '0;
        end else begin
            raw_prev_q <= tmds_raw;
            sym_q      <= aligned;
        end
    end

    always_comb begin
        sym_tok = is_token(sym_q);
        sym_vd  = tmds_data(sym_q);
        vd_d    = sym_tok ? vd_q : sym_vd;
        cd_d    = sym_tok ? token_cd(sym_q) : cd_q;
        vde_d   = !sym_tok && (state_q == LOCKED);
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            vd_q  <= '0;
            cd_q  <= '0;
            vde_q <= 1'b0;
        end else begin
            vd_q  <= vd_d;
            cd_q  <= cd_d;
            vde_q <= vde_d;
        end
    end

    // Lock detection takes priority over the offset advance in the same cycle.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEARCH;
            offset_q   <= '0;
            srch_cnt_q <= '0;
            tok_cnt_q  <= '0;
            loss_cnt_q <= '0;
        end else if (state_q == SEARCH) begin
            if (sym_tok && (tok_cnt_q == TOK_LAST)) begin
                state_q    <= LOCKED;
                srch_cnt_q <= '0;
                tok_cnt_q  <= '0;
                loss_cnt_q <= '0;
            end else if (srch_cnt_q == SRCH_LAST) begin
                offset_q   <= (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                srch_cnt_q <= '0;
                tok_cnt_q  <= '0;
            end else begin
                srch_cnt_q <= srch_cnt_q + 1'b1;
                tok_cnt_q  <= sym_tok ? tok_cnt_q + 1'b1 : '0;
            end
        end else begin
            if (sym_tok) begin
                loss_cnt_q <= '0;
            end else if (loss_cnt_q == LOSS_LAST) begin
                state_q    <= SEARCH;
                loss_cnt_q <= '0;
                srch_cnt_q <= '0;
                tok_cnt_q  <= '0;
            end else begin
                loss_cnt_q <= loss_cnt_q + 1'b1;
            end
        end
    end

    assign locked = (state_q == LOCKED);
    assign offset = offset_q;
    assign vd     = vd_q;
    assign cd     = cd_q;
    assign vde    = vde_q && locked;

`ifdef TMDS_DECODER_ERRCNT_EN
    // The encoder picks XNOR exactly when the data has >4 ones, or 4 ones with bit 0 clear.
    function automatic logic rule_violation(input logic q8, input logic [7:0] v);
        int   ones;
        logic want_xnor;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            ones += int'(v[i]);
        end
        want_xnor = (ones > 4) || ((ones == 4) && !v[0]);
        return want_xnor == q8;
    endfunction

    logic        err_d;
    logic        sym_err_q;
    logic [15:0] err_cnt_q;

    assign err_d = !sym_tok && (state_q == LOCKED) && rule_violation(sym_q[8], sym_vd);

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            sym_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            sym_err_q <= err_d;
            if (err_d && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign sym_err   = sym_err_q && locked;
    assign err_count = err_cnt_q;
`else
    assign sym_err   = 1'b0;
    assign err_count = '0;
`endif

endmodule
